// File: rtl/seg_scan_mux_if.sv
// Bus bundle between the taximeter display host (master) and seg_scan_mux (slave).
// Page values, decimal points and mode controls go in; digit strobe, segments and page come out.
interface seg_scan_mux_if #(
   parameter int DIGITS = 4,
   parameter int PAGES  = 3,
   parameter int VAL_W  = 14
);
   localparam int PS_W = $clog2(PAGES);
   localparam int DP_W = $clog2(DIGITS + 1);

   logic [PS_W-1:0]        page_sel;
   logic                   auto_en;
   logic                   blank_lz;
   logic [PAGES*VAL_W-1:0] page_val;
   logic [PAGES*DP_W-1:0]  dp_pos;
   logic [DIGITS-1:0]      seg;
   logic [7:0]             codeout;
   logic [PS_W-1:0]        cur_page;

   modport master (
      output page_sel, auto_en, blank_lz, page_val, dp_pos,
      input  seg, codeout, cur_page
   );

   modport slave (
      input  page_sel, auto_en, blank_lz, page_val, dp_pos,
      output seg, codeout, cur_page
   );
endinterface

// File: rtl/seg_scan_mux.sv
// Multi-page seven-segment scan controller: frame-synchronous page select, iterative
// binary-to-BCD conversion, leading-zero blanking, decimal point and overflow dashes.
module seg_scan_mux #(
   parameter int DIGITS      = 4,
   parameter int PAGES       = 3,
   parameter int VAL_W       = 14,
   parameter int SCAN_DIV    = 1000,
   parameter int AUTO_FRAMES = 250
) (
   input logic           clk,
   input logic           rst_n,
   seg_scan_mux_if.slave bus
);
   localparam int PS_W  = $clog2(PAGES);
   localparam int DP_W  = $clog2(DIGITS + 1);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BIT_W = $clog2(VAL_W + 1);
   localparam int FC_W  = $clog2(AUTO_FRAMES + 1);
   localparam int BCD_W = 4 * DIGITS;
   localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_SHIFT = 2'd2, ST_DONE = 2'd3} state_t;

   function automatic logic [7:0] digit_pat(input logic [3:0] d);
      case (d)
         4'd0:    digit_pat = 8'b1111_1100;
         4'd1:    digit_pat = 8'b0110_0000;
         4'd2:    digit_pat = 8'b1101_1010;
         4'd3:    digit_pat = 8'b1111_0010;
         4'd4:    digit_pat = 8'b0110_0110;
         4'd5:    digit_pat = 8'b1011_0110;
         4'd6:    digit_pat = 8'b1011_1110;
         4'd7:    digit_pat = 8'b1110_0000;
         4'd8:    digit_pat = 8'b1111_1110;
         4'd9:    digit_pat = 8'b1111_0110;
         default: digit_pat = 8'b0000_0000;
      endcase
   endfunction

   logic [DIV_W-1:0]  prescaler_q, prescaler_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              start_q;
   logic [PS_W-1:0]   cur_page_q, cur_page_d;
   logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic              auto_prev_q;
   state_t            state_q, state_d;
   logic [VAL_W-1:0]  bin_q, bin_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d, adj_s;
   logic              ovf_q, ovf_d;
   logic [DP_W-1:0]   dp_q, dp_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [BCD_W-1:0]  disp_bcd_q, disp_bcd_d;
   logic              disp_ovf_q, disp_ovf_d;
   logic [DP_W-1:0]   disp_dp_q, disp_dp_d;
   logic [DIGITS-1:0] seg_q, seg_d;
   logic [7:0]        codeout_q, codeout_d;
   logic              div_end_s, frame_bnd_s, auto_wrap_s;
   logic [VAL_W-1:0]  sel_val_s;
   logic [DP_W-1:0]   sel_dp_s;

   assign div_end_s = (prescaler_q == DIV_W'(SCAN_DIV - 1));
   assign sel_val_s = bus.page_val[int'(cur_page_q) * VAL_W +: VAL_W];
   assign sel_dp_s  = bus.dp_pos[int'(cur_page_q) * DP_W +: DP_W];

   // Digit scan timing; the first cycle out of reset acts as a frame boundary.
   always_comb begin
      prescaler_d = prescaler_q;
      idx_d       = idx_q;
      frame_bnd_s = 1'b0;
      if (start_q || (div_end_s && idx_q == IDX_W'(DIGITS - 1))) begin
         frame_bnd_s = 1'b1;
         prescaler_d = DIV_W'(0);
         idx_d       = IDX_W'(0);
      end else if (div_end_s) begin
         prescaler_d = DIV_W'(0);
         idx_d       = idx_q + IDX_W'(1);
      end else begin
         prescaler_d = prescaler_q + DIV_W'(1);
      end
   end

   assign auto_wrap_s = bus.auto_en && auto_prev_q && frame_bnd_s &&
                        (frame_cnt_q == FC_W'(AUTO_FRAMES - 1));

   // Page selection, applied only at frame boundaries.
   always_comb begin
      cur_page_d  = cur_page_q;
      frame_cnt_d = frame_cnt_q;
      if ((bus.auto_en != auto_prev_q) || auto_wrap_s) begin
         frame_cnt_d = FC_W'(0);
      end else if (frame_bnd_s && bus.auto_en) begin
         frame_cnt_d = frame_cnt_q + FC_W'(1);
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
      if (auto_wrap_s) begin
         cur_page_d = (cur_page_q == PS_W'(PAGES - 1)) ? PS_W'(0) : cur_page_q + PS_W'(1);
      end else if (frame_bnd_s && !bus.auto_en && (int'(bus.page_sel) < PAGES)) begin
         cur_page_d = bus.page_sel;
      end else begin
         cur_page_d = cur_page_q;
      end
   end

   // Shift-add-3 converter; results reach the display only at a frame boundary.
   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      dp_d       = dp_q;
      bit_cnt_d  = bit_cnt_q;
      disp_bcd_d = disp_bcd_q;
      disp_ovf_d = disp_ovf_q;
      disp_dp_d  = disp_dp_q;
      adj_s      = bcd_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) adj_s[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         else                         adj_s[4*k +: 4] = bcd_q[4*k +: 4];
      end
      case (state_q)
         ST_IDLE: begin
            if (frame_bnd_s) state_d = ST_LOAD;
            else             state_d = ST_IDLE;
         end
         ST_LOAD: begin
            bin_d     = sel_val_s;
            bcd_d     = {BCD_W{1'b0}};
            ovf_d     = (64'(sel_val_s) > MAX_VAL);
            dp_d      = sel_dp_s;
            bit_cnt_d = BIT_W'(0);
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            bcd_d     = {adj_s[BCD_W-2:0], bin_q[VAL_W-1]};
            bin_d     = bin_q << 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(VAL_W - 1)) state_d = ST_DONE;
            else                                state_d = ST_SHIFT;
         end
         ST_DONE: begin
            if (frame_bnd_s) begin
               disp_bcd_d = bcd_q;
               disp_ovf_d = ovf_q;
               disp_dp_d  = dp_q;
               state_d    = ST_LOAD;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobe and segment pattern for the digit lit after this edge.
   always_comb begin
      logic       zero_run;
      logic       blank;
      logic [3:0] digit;
      zero_run = 1'b1;
      blank    = 1'b0;
      seg_d    = {DIGITS{1'b0}};
      for (int k = 0; k < DIGITS; k++) seg_d[k] = (int'(idx_d) == k);
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_run = zero_run && (disp_bcd_d[4*k +: 4] == 4'd0);
         if (bus.blank_lz && zero_run && (int'(idx_d) == k) &&
             ((int'(disp_dp_d) >= DIGITS) || (k > int'(disp_dp_d)))) blank = 1'b1;
         else blank = blank;
      end
      digit = disp_bcd_d[int'(idx_d) * 4 +: 4];
      if (disp_ovf_d)  codeout_d = 8'b0000_0010;
      else if (blank)  codeout_d = 8'b0000_0000;
      else             codeout_d = digit_pat(digit) | {7'b000_0000, (int'(disp_dp_d) == int'(idx_d))};
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler_q <= DIV_W'(0);
         idx_q       <= IDX_W'(0);
         start_q     <= 1'b1;
         cur_page_q  <= PS_W'(0);
         frame_cnt_q <= FC_W'(0);
         auto_prev_q <= 1'b0;
         state_q     <= ST_IDLE;
         bin_q       <= VAL_W'(0);
         bcd_q       <= BCD_W'(0);
         ovf_q       <= 1'b0;
         dp_q        <= DP_W'(DIGITS);
         bit_cnt_q   <= BIT_W'(0);
         disp_bcd_q  <= BCD_W'(0);
         disp_ovf_q  <= 1'b0;
         disp_dp_q   <= DP_W'(DIGITS);
         seg_q       <= {DIGITS{1'b0}};
         codeout_q   <= 8'b0000_0000;
      end else begin
         prescaler_q <= prescaler_d;
         idx_q       <= idx_d;
         start_q     <= 1'b0;
         cur_page_q  <= cur_page_d;
         frame_cnt_q <= frame_cnt_d;
         auto_prev_q <= bus.auto_en;
         state_q     <= state_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         ovf_q       <= ovf_d;
         dp_q        <= dp_d;
         bit_cnt_q   <= bit_cnt_d;
         disp_bcd_q  <= disp_bcd_d;
         disp_ovf_q  <= disp_ovf_d;
         disp_dp_q   <= disp_dp_d;
         seg_q       <= seg_d;
         codeout_q   <= codeout_d;
      end
   end

   assign bus.seg      = seg_q;
   assign bus.codeout  = codeout_q;
   assign bus.cur_page = cur_page_q;
endmodule
